// File: rtl/wd_reset_sequencer_if.sv
// Signal bundle between the watchdog/reset sequencer and its surroundings
// (address decoder strobes, video VBLANK, CPU reset and status).
interface wd_reset_sequencer_if;
  logic       vblank;
  logic       wdog_kick;
  logic       wdis_n;
  logic       ext_reset_req;
  logic       cpu_reset_n;
  logic [3:0] wd_count;
  logic       wd_fired;
  logic [1:0] reset_cause;
  logic [7:0] trip_total;

  modport master (
    output vblank, wdog_kick, wdis_n, ext_reset_req,
    input  cpu_reset_n, wd_count, wd_fired, reset_cause, trip_total
  );

  modport slave (
    input  vblank, wdog_kick, wdis_n, ext_reset_req,
    output cpu_reset_n, wd_count, wd_fired, reset_cause, trip_total
  );
endinterface

// File: rtl/wd_reset_sequencer.sv
// CPU reset stretcher with VBLANK-frame watchdog: holds cpu_reset_n low after
// power-on, watchdog trip or external request, and records the last cause.
module wd_reset_sequencer #(
  parameter int unsigned WD_LIMIT    = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wd_reset_sequencer_if.slave  bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        WD_LAST   = 4'(WD_LIMIT - 1);
  localparam logic [1:0]        CAUSE_POR = 2'b00;
  localparam logic [1:0]        CAUSE_WD  = 2'b01;
  localparam logic [1:0]        CAUSE_EXT = 2'b10;

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t                 state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [SYNC_STAGES-1:0] vb_sync;
  logic                   vb_prev;
  logic                   vb_rise_c;
  logic                   cpu_reset_q;
  logic [3:0]             wd_count_q;
  logic                   wd_fired_q;
  logic [1:0]             reset_cause_q;
  logic [7:0]             trip_total_q;

  // VBLANK synchroniser plus edge register; vb_rise_c is one clk per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vb_sync <= '0;
      vb_prev <= 1'b0;
    end else begin
      vb_sync <= {vb_sync[SYNC_STAGES-2:0], bus.vblank};
      vb_prev <= vb_sync[SYNC_STAGES-1];
    end
  end

  assign vb_rise_c = vb_sync[SYNC_STAGES-1] & ~vb_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_HOLD;
      hold_cnt      <= '0;
      cpu_reset_q   <= 1'b0;
      wd_count_q    <= 4'd0;
      wd_fired_q    <= 1'b0;
      reset_cause_q <= CAUSE_POR;
      trip_total_q  <= 8'd0;
    end else begin
      wd_fired_q <= 1'b0;
      case (state)
        ST_HOLD: begin
          wd_count_q <= 4'd0;
          if (bus.ext_reset_req) begin
            hold_cnt      <= '0;
            reset_cause_q <= CAUSE_EXT;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= ST_RUN;
            cpu_reset_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (bus.ext_reset_req) begin
            state         <= ST_HOLD;
            hold_cnt      <= '0;
            cpu_reset_q   <= 1'b0;
            wd_count_q    <= 4'd0;
            reset_cause_q <= CAUSE_EXT;
          end else if (!bus.wdis_n || bus.wdog_kick) begin
            wd_count_q <= 4'd0;
          end else if (vb_rise_c) begin
            // Last allowed frame elapsed without a kick: trip.
            if (wd_count_q == WD_LAST) begin
              state         <= ST_HOLD;
              hold_cnt      <= '0;
              cpu_reset_q   <= 1'b0;
              wd_count_q    <= 4'd0;
              reset_cause_q <= CAUSE_WD;
              wd_fired_q    <= 1'b1;
              trip_total_q  <= (trip_total_q == 8'hFF) ? trip_total_q : trip_total_q + 8'd1;
            end else begin
              wd_count_q <= wd_count_q + 4'd1;
            end
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  assign bus.cpu_reset_n = cpu_reset_q;
  assign bus.wd_count    = wd_count_q;
  assign bus.wd_fired    = wd_fired_q;
  assign bus.reset_cause = reset_cause_q;
  assign bus.trip_total  = trip_total_q;

endmodule

// File: tb/tb_wd_reset_sequencer.sv
// Bench for wd_reset_sequencer: frame-level model compared every cycle, plus
// directed scenarios with literal expectations and a randomized frame phase.
module tb_wd_reset_sequencer;
  localparam int unsigned WD_LIMIT    = 8;
  localparam int unsigned HOLD_CYCLES = 16;
  localparam int unsigned SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wd_reset_sequencer_if bus();

  wd_reset_sequencer #(
    .WD_LIMIT(WD_LIMIT), .HOLD_CYCLES(HOLD_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int fired_seen = 0;

  // low_left = clocks of CPU reset still to go; CPU runs when it is zero.
  typedef struct packed {
    logic [4:0] low_left;
    logic [3:0] cnt;
    logic       fired;
    logic [1:0] cause;
    logic [7:0] trips;
  } model_t;

  model_t               m;
  logic [SYNC_STAGES:0] vb_hist;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t next_model(model_t s, logic rise, logic ext, logic kick, logic wdis_n);
    model_t n = s;
    n.fired = 1'b0;
    if (s.low_left != 5'd0) begin
      n.cnt = 4'd0;
      if (ext) begin
        n.low_left = 5'(HOLD_CYCLES);
        n.cause    = 2'd2;
      end else begin
        n.low_left = s.low_left - 5'd1;
      end
    end else if (ext) begin
      n.low_left = 5'(HOLD_CYCLES);
      n.cause    = 2'd2;
      n.cnt      = 4'd0;
    end else if (!wdis_n || kick) begin
      n.cnt = 4'd0;
    end else if (rise) begin
      if (int'(s.cnt) + 1 == int'(WD_LIMIT)) begin
        n.low_left = 5'(HOLD_CYCLES);
        n.cnt      = 4'd0;
        n.cause    = 2'd1;
        n.fired    = 1'b1;
        if (s.trips != 8'd255) n.trips = s.trips + 8'd1;
      end else begin
        n.cnt = s.cnt + 4'd1;
      end
    end
    return n;
  endfunction

  // A VBLANK level sampled at edge k is seen as a frame start at edge k+SYNC_STAGES.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m       <= {5'(HOLD_CYCLES), 15'd0};
      vb_hist <= '0;
    end else begin
      m <= next_model(m, vb_hist[SYNC_STAGES-1] & ~vb_hist[SYNC_STAGES],
                      bus.ext_reset_req, bus.wdog_kick, bus.wdis_n);
      vb_hist <= {vb_hist[SYNC_STAGES-1:0], bus.vblank};
    end
  end

  always @(negedge clk) begin
    check("cpu_reset_n", 8'(bus.cpu_reset_n), 8'(m.low_left == 5'd0));
    check("wd_count",    8'(bus.wd_count),    8'(m.cnt));
    check("wd_fired",    8'(bus.wd_fired),    8'(m.fired));
    check("reset_cause", 8'(bus.reset_cause), 8'(m.cause));
    check("trip_total",  bus.trip_total,      m.trips);
    if (bus.wd_fired === 1'b1) fired_seen++;
  end

  task automatic drive(input logic vb, input logic kick, input logic ext);
    @(negedge clk);
    #1;
    bus.vblank        = vb;
    bus.wdog_kick     = kick;
    bus.ext_reset_req = ext;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // One video frame: hi clks of VBLANK then lo clks low; strobes at given offsets (-1 = none).
  task automatic frame(input int hi, input int lo, input int kick_off, input int ext_off);
    for (int i = 0; i < hi + lo; i++)
      drive(logic'(i < hi), logic'(i == kick_off), logic'(i == ext_off));
    idle(1);
  endtask

  // Clocks until cpu_reset_n is seen high, bounded.
  task automatic count_low(output int n);
    n = 0;
    while (bus.cpu_reset_n !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int kick_pct;
    int hi;
    int lo;
    int ko;
    int eo;
    bus.vblank        = 1'b0;
    bus.wdog_kick     = 1'b0;
    bus.ext_reset_req = 1'b0;
    bus.wdis_n        = 1'b1;

    // Power-on reset stretch
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    count_low(n);
    check("por_hold_len", 8'(n), 8'd16);
    check("por_cause", 8'(bus.reset_cause), 8'd0);
    check("por_count", 8'(bus.wd_count), 8'd0);

    // Kicked every frame after the frame start
    for (int f = 0; f < 50; f++)
      frame($urandom_range(2, 4), $urandom_range(6, 11), $urandom_range(SYNC_STAGES + 1, SYNC_STAGES + 3), -1);
    check("kick_cpu_up", 8'(bus.cpu_reset_n), 8'd1);
    check("kick_no_fire", 8'(fired_seen), 8'd0);

    // Eight unkicked frames trip the watchdog
    for (int f = 0; f < 8; f++) frame(2, 20, -1, -1);
    check("trip_fired_once", 8'(fired_seen), 8'd1);
    check("trip_cause", 8'(bus.reset_cause), 8'd1);
    check("trip_total1", bus.trip_total, 8'd1);
    check("trip_count", 8'(bus.wd_count), 8'd0);
    check("trip_recovered", 8'(bus.cpu_reset_n), 8'd1);

    // Disabled watchdog never trips; released, it trips after eight frames
    bus.wdis_n = 1'b0;
    for (int f = 0; f < 100; f++) frame(2, 4, -1, -1);
    check("dis_count", 8'(bus.wd_count), 8'd0);
    check("dis_trips", bus.trip_total, 8'd1);
    bus.wdis_n = 1'b1;
    for (int f = 0; f < 7; f++) frame(2, 20, -1, -1);
    check("rel_count7", 8'(bus.wd_count), 8'd7);
    check("rel_trips_pre", bus.trip_total, 8'd1);
    frame(2, 20, -1, -1);
    check("rel_trips_post", bus.trip_total, 8'd2);

    // Kick coincident with the tripping frame start
    for (int f = 0; f < 7; f++) frame(2, 6, -1, -1);
    check("co_count7", 8'(bus.wd_count), 8'd7);
    frame(2, 6, SYNC_STAGES, -1);
    check("co_kick_count", 8'(bus.wd_count), 8'd0);
    check("co_kick_trips", bus.trip_total, 8'd2);

    // External request coincident with a trip
    for (int f = 0; f < 7; f++) frame(2, 6, -1, -1);
    frame(2, 20, -1, SYNC_STAGES);
    check("co_ext_cause", 8'(bus.reset_cause), 8'd2);
    check("co_ext_trips", bus.trip_total, 8'd2);
    check("co_ext_nofire", 8'(fired_seen), 8'd2);

    // External request mid-hold restarts the stretch
    idle(5);
    drive(1'b0, 1'b0, 1'b1);
    idle(10);
    drive(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 bus.ext_reset_req = 1'b0;
    count_low(n);
    check("ext_restart_len", 8'(n), 8'd16);
    check("ext_cause", 8'(bus.reset_cause), 8'd2);

    // reset_n pulse mid-run
    idle(5);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst_cpu", 8'(bus.cpu_reset_n), 8'd0);
    check("rst_trips", bus.trip_total, 8'd0);
    check("rst_cause", 8'(bus.reset_cause), 8'd0);
    check("rst_count", 8'(bus.wd_count), 8'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    count_low(n);
    check("rst_hold_len", 8'(n), 8'd16);

    // Randomized frames, alternating well-kicked and neglected epochs
    for (int f = 0; f < 300; f++) begin
      kick_pct = ((f / 50) % 2 == 0) ? 85 : 10;
      hi = $urandom_range(1, 4);
      lo = $urandom_range(3, 22);
      ko = ($urandom_range(0, 99) < kick_pct) ? $urandom_range(0, hi + lo - 1) : -1;
      eo = ($urandom_range(0, 39) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
      bus.wdis_n = ($urandom_range(0, 9) != 0);
      frame(hi, lo, ko, eo);
    end
    bus.wdis_n = 1'b1;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
